// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// default divide timeout, the NOP the flush paths load, and the
// load-use hazard predicate.
package pipe_hazard_ctrl_pkg;

  // Controller states
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  // Default cycle budget for a single divide before it is aborted
  localparam int unsigned DIV_TIMEOUT_DEF = 64;

  // addi x0, x0, 0 -- what IF/ID and ID/EX load when flushed
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A load in execute whose rd (non-zero) feeds either source of decode
  function automatic logic load_use_hit(
    input logic       ld,
    input logic       we,
    input logic [4:0] wa,
    input logic [4:0] r1,
    input logic [4:0] r2
  );
    return ld & we & (wa != 5'd0) & ((wa == r1) | (wa == r2));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones. Synchronous
// clear has priority over enable.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count up on enable, hold at the maximum value
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hold/flush sequencing for the five-stage core. Handles taken jumps
// from execute, load-use bubbles, and freezes the front end while the
// shared divider is busy (with a timeout abort).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; jump > divide start > load-use bubble
// DIV_WAIT | divider busy; front end frozen until done or timeout
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_reg1_addr_i,
  input  logic [4:0]       id_reg2_addr_i,
  input  logic             ex_load_i,
  input  logic             ex_wr_en_i,
  input  logic [4:0]       ex_wr_addr_i,
  input  logic             ex_div_i,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             div_done_i,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             redirect_en_o,
  output logic [31:0]      redirect_addr_o,
  output logic             div_start_o,
  output logic             div_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Timeout counter only needs to reach DIV_TIMEOUT-1
  localparam int unsigned TO_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DIV_TIMEOUT - 1);

  state_t          state;
  state_t          state_next;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  logic            hazard;

  assign hazard = load_use_hit(ex_load_i, ex_wr_en_i, ex_wr_addr_i,
                               id_reg1_addr_i, id_reg2_addr_i);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and Mealy outputs; everything forced low during reset
  always_comb begin
    state_next      = state;
    hold_pc_o       = 1'b0;
    hold_if_id_o    = 1'b0;
    hold_id_ex_o    = 1'b0;
    flush_if_id_o   = 1'b0;
    flush_id_ex_o   = 1'b0;
    redirect_en_o   = 1'b0;
    redirect_addr_o = 32'd0;
    div_start_o     = 1'b0;
    timeout         = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (jump_en_i) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed
            redirect_en_o   = 1'b1;
            redirect_addr_o = jump_addr_i;
            flush_if_id_o   = 1'b1;
            flush_id_ex_o   = 1'b1;
          end else if (ex_div_i) begin
            div_start_o  = 1'b1;
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
            state_next   = DIV_WAIT;
          end else if (hazard) begin
            // Decode waits one cycle; a bubble goes into execute
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
          end
        end
        DIV_WAIT: begin
          if (div_done_i) begin
            state_next = RUN;
          end else if (to_cnt == TO_LAST) begin
            timeout    = 1'b1;
            state_next = RUN;
          end else begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Sticky divide-timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      div_err_o <= 1'b0;
    end else if (timeout) begin
      div_err_o <= 1'b1;
    end
  end

  // Cycles spent in DIV_WAIT; zero whenever the divider is idle
  sat_counter #(.W(TO_W)) u_to_cnt (
    .clk   (clk),
    .clr   (rst | (state != DIV_WAIT)),
    .en    (state == DIV_WAIT),
    .count (to_cnt)
  );

  // Total front-end stall cycles
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (hold_pc_o),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver applies one input
// vector per cycle and queues the reference model's expected outputs;
// a monitor on the falling edge pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int TO = 40;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    a1 = '0, a2 = '0, wa = '0;
  logic          ld = 1'b0, we = 1'b0, dv = 1'b0, jp = 1'b0, dd = 1'b0;
  logic [31:0]   ja = '0;

  logic          hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;
  logic          redirect_en, div_start, div_err;
  logic [31:0]   redirect_addr;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_addr_i  (a1),
    .id_reg2_addr_i  (a2),
    .ex_load_i       (ld),
    .ex_wr_en_i      (we),
    .ex_wr_addr_i    (wa),
    .ex_div_i        (dv),
    .jump_en_i       (jp),
    .jump_addr_i     (ja),
    .div_done_i      (dd),
    .hold_pc_o       (hold_pc),
    .hold_if_id_o    (hold_if_id),
    .hold_id_ex_o    (hold_id_ex),
    .flush_if_id_o   (flush_if_id),
    .flush_id_ex_o   (flush_id_ex),
    .redirect_en_o   (redirect_en),
    .redirect_addr_o (redirect_addr),
    .div_start_o     (div_start),
    .div_err_o       (div_err),
    .stall_cnt_o     (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hpc, hif, hid, fif, fid, ren;
    logic [31:0]   radr;
    logic          dst, derr;
    logic [CW-1:0] scnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: divider busy flag, cycles waited, error, stall total
  bit m_div = 0;
  int m_wait = 0;
  bit m_err = 0;
  int m_stall = 0;

  task automatic step(input logic r, input logic [4:0] r1, input logic [4:0] r2,
                      input logic l, input logic w, input logic [4:0] d,
                      input logic v, input logic j, input logic [31:0] t,
                      input logic dn);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; a1 = r1; a2 = r2; ld = l; we = w; wa = d;
    dv = v; jp = j; ja = t; dd = dn;
    e = '0;
    e.derr = m_err;
    e.scnt = CW'(m_stall);
    if (r) begin
      m_div = 0; m_wait = 0; m_err = 0; m_stall = 0;
    end else begin
      if (!m_div) begin
        if (j) begin
          e.ren = 1; e.radr = t; e.fif = 1; e.fid = 1;
        end else if (v) begin
          e.dst = 1; e.hpc = 1; e.hif = 1; e.hid = 1;
          m_div = 1; m_wait = 0;
        end else if (l && w && d != 0 && (d == r1 || d == r2)) begin
          e.hpc = 1; e.hif = 1; e.fid = 1;
        end
      end else begin
        if (dn) begin
          m_div = 0;
        end else if (m_wait == TO - 1) begin
          m_err = 1; m_div = 0;
        end else begin
          e.hpc = 1; e.hif = 1; e.hid = 1;
          m_wait++;
        end
      end
      if (e.hpc && m_stall < (1 << CW) - 1) m_stall++;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input logic dn);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 32'd0, dn);
  endtask

  task automatic div_go();
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        chk("hold_pc",       32'(hold_pc),       32'(e.hpc));
        chk("hold_if_id",    32'(hold_if_id),    32'(e.hif));
        chk("hold_id_ex",    32'(hold_id_ex),    32'(e.hid));
        chk("flush_if_id",   32'(flush_if_id),   32'(e.fif));
        chk("flush_id_ex",   32'(flush_id_ex),   32'(e.fid));
        chk("redirect_en",   32'(redirect_en),   32'(e.ren));
        chk("redirect_addr", redirect_addr,      e.radr);
        chk("div_start",     32'(div_start),     32'(e.dst));
        chk("div_err",       32'(div_err),       32'(e.derr));
        chk("stall_cnt",     32'(stall_cnt),     32'(e.scnt));
      end
    end
  end

  initial begin
    #5_000_000;
    miscompares++;
    $display("FAIL watchdog: run did not end, %0d expectations pending", sb.size());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    repeat (3) step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 32'd0, 0);

    // Load-use on rs2, then the same with rd = x0
    step(0, 5'd1, 5'd5, 1, 1, 5'd5, 0, 0, 32'd0, 0);
    idle(0);
    step(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 32'd0, 0);
    idle(0);

    // Jump with a concurrent hazard and divide
    step(0, 5'd7, 5'd2, 1, 1, 5'd7, 1, 1, 32'h0000_0100, 0);
    idle(0);

    // Divide returning after 33 hold cycles
    div_go();
    repeat (32) idle(0);
    idle(1);
    idle(0);

    // Timeout, then a done landing exactly on the timeout cycle
    div_go();
    repeat (TO + 2) idle(0);
    div_go();
    repeat (TO - 1) idle(0);
    idle(1);
    idle(0);

    // Back-to-back divides, done pulse in RUN ignored
    div_go();
    repeat (5) idle(0);
    idle(1);
    div_go();
    idle(1);
    idle(1);

    // Reset during the wait, nothing reissued afterwards
    div_go();
    repeat (3) idle(0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 32'd0, 0);
    repeat (3) idle(0);

    // Consecutive load-use stalls drive the stall counter to saturation
    repeat (70) step(0, 5'd3, 5'd0, 1, 1, 5'd3, 0, 0, 32'd0, 0);
    repeat (2) idle(0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           $urandom, ($urandom_range(0, 24) == 0));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
